// File: rtl/alu_issue_queue_if.sv
// Dispatch / CDB / issue bundle for one ALU issue queue.
//   enq_*  : up to two dispatched instructions per cycle (slot k, source s at index 2k+s)
//   cdb_*  : two result-bus write ports snooped for operand wakeup
//   iss_*  : valid/ready issue handshake towards the ALU
// slave is the queue side; master is the dispatch/CDB/ALU side.
interface alu_issue_queue_if #(
  parameter int unsigned PREG_W    = 6,
  parameter int unsigned PAYLOAD_W = 96
);
  logic                            enq_valid_i;
  logic                            enq_ready_o;
  logic [1:0]                      enq_choose_i;
  logic [3:0][31:0]                enq_data_i;
  logic [3:0][PREG_W-1:0]          enq_preg_i;
  logic [3:0]                      enq_data_valid_i;
  logic [1:0][PAYLOAD_W-1:0]       enq_payload_i;

  logic [1:0]                      cdb_w_reg_i;
  logic [1:0][PREG_W-1:0]          cdb_w_preg_i;
  logic [1:0][31:0]                cdb_w_data_i;

  logic                            iss_valid_o;
  logic                            iss_ready_i;
  logic [31:0]                     iss_src0_o;
  logic [31:0]                     iss_src1_o;
  logic [PAYLOAD_W-1:0]            iss_payload_o;

  modport slave (
    input  enq_valid_i, enq_choose_i, enq_data_i, enq_preg_i, enq_data_valid_i, enq_payload_i,
    input  cdb_w_reg_i, cdb_w_preg_i, cdb_w_data_i,
    input  iss_ready_i,
    output enq_ready_o, iss_valid_o, iss_src0_o, iss_src1_o, iss_payload_o
  );

  modport master (
    output enq_valid_i, enq_choose_i, enq_data_i, enq_preg_i, enq_data_valid_i, enq_payload_i,
    output cdb_w_reg_i, cdb_w_preg_i, cdb_w_data_i,
    output iss_ready_i,
    input  enq_ready_o, iss_valid_o, iss_src0_o, iss_src1_o, iss_payload_o
  );
endinterface

// File: rtl/alu_issue_queue.sv
// Out-of-order ALU issue queue (collapsing, entry 0 oldest).
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   flush_i   : empties the queue; wins over enqueue, wakeup and issue
//   bus       : dispatch enqueue, CDB snoop ports and ALU issue handshake
//   count_o   : number of occupied entries
// Each cycle the oldest entry with both operands ready is presented for issue. Operands
// waiting on a tag are woken by the CDB one cycle before they can be selected.
module alu_issue_queue #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned PREG_W    = 6,
  parameter int unsigned PAYLOAD_W = 96
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  alu_issue_queue_if.slave           bus,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][1:0][31:0]       data_q, data_d, data_w;
  logic [DEPTH-1:0][1:0][PREG_W-1:0] tag_q, tag_d;
  logic [DEPTH-1:0][1:0]             rdy_q, rdy_d, rdy_w;
  logic [DEPTH-1:0][PAYLOAD_W-1:0]   payload_q, payload_d;
  logic [CW-1:0]                     count_q, count_d;

  logic [DEPTH-1:0][1:0][32:0]       ent_snp;
  logic [3:0][32:0]                  enq_snp;
  logic [DEPTH-1:0]                  elig;
  logic [IW-1:0]                     sel;
  logic                              iss_valid, enq_ready, issue_fire, enq_fire;
  int                                base, pos, src;

  // Returns {hit, OR of matching CDB data}.
  function automatic logic [32:0] cdb_snoop(input logic [PREG_W-1:0]      tag,
                                            input logic [1:0]             wr,
                                            input logic [1:0][PREG_W-1:0] ptag,
                                            input logic [1:0][31:0]       pdata);
    logic [32:0] r;
    r = '0;
    for (int j = 0; j < 2; j++) begin
      if (wr[j] && (ptag[j] == tag)) r = r | {1'b1, pdata[j]};
    end
    return r;
  endfunction

  // Snoop both stored entries and incoming operands against the CDB.
  always_comb begin
    ent_snp = '0;
    enq_snp = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int s = 0; s < 2; s++) begin
        ent_snp[i][s] = cdb_snoop(tag_q[i][s], bus.cdb_w_reg_i, bus.cdb_w_preg_i,
                                  bus.cdb_w_data_i);
      end
    end
    for (int n = 0; n < 4; n++) begin
      enq_snp[n] = cdb_snoop(bus.enq_preg_i[n], bus.cdb_w_reg_i, bus.cdb_w_preg_i,
                             bus.cdb_w_data_i);
    end
  end

  // Wakeup result, applied before the collapse so it travels with the entry.
  always_comb begin
    rdy_w  = rdy_q;
    data_w = data_q;
    for (int i = 0; i < DEPTH; i++) begin
      for (int s = 0; s < 2; s++) begin
        if (!rdy_q[i][s] && ent_snp[i][s][32]) begin
          rdy_w[i][s]  = 1'b1;
          data_w[i][s] = ent_snp[i][s][31:0];
        end
      end
    end
  end

  // Oldest-ready select over registered state only (no same-cycle CDB bypass).
  always_comb begin
    elig      = '0;
    iss_valid = 1'b0;
    sel       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      elig[i] = (i < int'(count_q)) && rdy_q[i][0] && rdy_q[i][1];
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (elig[i]) begin
        iss_valid = 1'b1;
        sel       = IW'(i);
      end
    end
  end

  assign enq_ready  = (count_q <= CW'(DEPTH - 2));
  assign issue_fire = iss_valid && bus.iss_ready_i && !flush_i;
  assign enq_fire   = bus.enq_valid_i && enq_ready && !flush_i;

  // Collapse the issued entry out, then append selected slots at the new tail.
  always_comb begin
    rdy_d     = '0;
    data_d    = data_w;
    tag_d     = tag_q;
    payload_d = payload_q;
    src       = 0;
    for (int i = 0; i < DEPTH; i++) begin
      src = i;
      if (issue_fire && (i >= int'(sel))) src = i + 1;
      if (src < int'(DEPTH)) begin
        rdy_d[i]     = rdy_w[src];
        data_d[i]    = data_w[src];
        tag_d[i]     = tag_q[src];
        payload_d[i] = payload_q[src];
      end
    end

    base = int'(count_q) - (issue_fire ? 1 : 0);
    pos  = base;
    for (int k = 0; k < 2; k++) begin
      if (enq_fire && bus.enq_choose_i[k]) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (i == pos) begin
            payload_d[i] = bus.enq_payload_i[k];
            for (int s = 0; s < 2; s++) begin
              tag_d[i][s] = bus.enq_preg_i[2*k+s];
              rdy_d[i][s] = bus.enq_data_valid_i[2*k+s] | enq_snp[2*k+s][32];
              if (!bus.enq_data_valid_i[2*k+s] && enq_snp[2*k+s][32]) begin
                data_d[i][s] = enq_snp[2*k+s][31:0];
              end else begin
                data_d[i][s] = bus.enq_data_i[2*k+s];
              end
            end
          end
        end
        pos = pos + 1;
      end
    end
    count_d = CW'(pos);
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      count_q <= '0;
      rdy_q   <= '0;
    end else begin
      count_q <= count_d;
      rdy_q   <= rdy_d;
    end
    data_q    <= data_d;
    tag_q     <= tag_d;
    payload_q <= payload_d;
  end

  assign bus.enq_ready_o   = enq_ready;
  assign bus.iss_valid_o   = iss_valid;
  assign bus.iss_src0_o    = iss_valid ? data_q[sel][0] : '0;
  assign bus.iss_src1_o    = iss_valid ? data_q[sel][1] : '0;
  assign bus.iss_payload_o = iss_valid ? payload_q[sel] : '0;
  assign count_o           = count_q;

  a_count_le_depth: assert property (@(posedge clk) disable iff (rst) count_q <= CW'(DEPTH));

endmodule

// File: tb/tb_alu_issue_queue.sv
module tb_alu_issue_queue;
  localparam int unsigned DEPTH     = 8;
  localparam int unsigned PREG_W    = 6;
  localparam int unsigned PAYLOAD_W = 96;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush_i = 1'b0;
  logic [3:0] count_o;
  int         n_vec = 0;
  int         n_err = 0;

  alu_issue_queue_if #(.PREG_W(PREG_W), .PAYLOAD_W(PAYLOAD_W)) bus ();

  alu_issue_queue #(.DEPTH(DEPTH), .PREG_W(PREG_W), .PAYLOAD_W(PAYLOAD_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush_i),
    .bus     (bus),
    .count_o (count_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_iss(input string tag, input logic [31:0] s0, input logic [31:0] s1,
                           input logic [95:0] pl);
    check_eq({tag, ".valid"}, 128'(bus.iss_valid_o), 128'(1));
    check_eq({tag, ".src0"}, 128'(bus.iss_src0_o), 128'(s0));
    check_eq({tag, ".src1"}, 128'(bus.iss_src1_o), 128'(s1));
    check_eq({tag, ".payload"}, 128'(bus.iss_payload_o), 128'(pl));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.enq_valid_i      = 1'b0;
    bus.enq_choose_i     = 2'b00;
    bus.enq_data_valid_i = 4'b0000;
    bus.cdb_w_reg_i      = 2'b00;
  endtask

  task automatic set_slot(input int k, input logic [31:0] d0, input logic v0,
                          input logic [5:0] p0, input logic [31:0] d1, input logic v1,
                          input logic [5:0] p1, input logic [95:0] pl);
    bus.enq_data_i[2*k]         = d0;
    bus.enq_data_valid_i[2*k]   = v0;
    bus.enq_preg_i[2*k]         = p0;
    bus.enq_data_i[2*k+1]       = d1;
    bus.enq_data_valid_i[2*k+1] = v1;
    bus.enq_preg_i[2*k+1]       = p1;
    bus.enq_payload_i[k]        = pl;
  endtask

  task automatic cdb(input int j, input logic [5:0] p, input logic [31:0] d);
    bus.cdb_w_reg_i[j]  = 1'b1;
    bus.cdb_w_preg_i[j] = p;
    bus.cdb_w_data_i[j] = d;
  endtask

  initial begin
    bus.enq_data_i    = '0;
    bus.enq_preg_i    = '0;
    bus.enq_payload_i = '0;
    bus.cdb_w_preg_i  = '0;
    bus.cdb_w_data_i  = '0;
    bus.iss_ready_i   = 1'b0;
    idle();

    // Reset
    step();
    step();
    rst = 1'b0;
    check_eq("rst.iss_valid", 128'(bus.iss_valid_o), 128'(0));
    check_eq("rst.count", 128'(count_o), 128'(0));
    check_eq("rst.enq_ready", 128'(bus.enq_ready_o), 128'(1));
    check_eq("rst.src0", 128'(bus.iss_src0_o), 128'(0));
    check_eq("rst.payload", 128'(bus.iss_payload_o), 128'(0));

    // Immediate issue, then CDB wakeup while the woken entry shifts down
    bus.iss_ready_i = 1'b1;
    set_slot(0, 32'h11, 1'b1, 6'd0, 32'h22, 1'b1, 6'd0, 96'hA0);
    set_slot(1, 32'h33, 1'b1, 6'd0, 32'h0, 1'b0, 6'd5, 96'hA1);
    bus.enq_choose_i = 2'b11;
    bus.enq_valid_i  = 1'b1;
    step();
    idle();
    check_eq("imm.count", 128'(count_o), 128'(2));
    check_eq("imm.enq_ready", 128'(bus.enq_ready_o), 128'(1));
    check_iss("imm.first", 32'h11, 32'h22, 96'hA0);
    cdb(0, 6'd5, 32'hABCD);
    step();
    idle();
    check_eq("imm.count1", 128'(count_o), 128'(1));
    check_iss("imm.woken", 32'h33, 32'hABCD, 96'hA1);
    step();
    check_eq("imm.count0", 128'(count_o), 128'(0));
    check_eq("imm.empty", 128'(bus.iss_valid_o), 128'(0));

    // Oldest-ready ordering; mask 2'b10 appends slot 1 alone
    bus.iss_ready_i = 1'b0;
    set_slot(0, 32'hA0, 1'b1, 6'd0, 32'h0, 1'b0, 6'd9, 96'hAA);
    set_slot(1, 32'hB0, 1'b1, 6'd0, 32'hB1, 1'b1, 6'd0, 96'hBB);
    bus.enq_choose_i = 2'b11;
    bus.enq_valid_i  = 1'b1;
    step();
    set_slot(1, 32'hC0, 1'b1, 6'd0, 32'hC1, 1'b1, 6'd0, 96'hCC);
    bus.enq_choose_i = 2'b10;
    step();
    idle();
    check_eq("ord.count3", 128'(count_o), 128'(3));
    check_iss("ord.b", 32'hB0, 32'hB1, 96'hBB);
    bus.iss_ready_i = 1'b1;
    step();
    check_eq("ord.count2", 128'(count_o), 128'(2));
    check_iss("ord.c", 32'hC0, 32'hC1, 96'hCC);
    step();
    check_eq("ord.count1", 128'(count_o), 128'(1));
    check_eq("ord.a_blocked", 128'(bus.iss_valid_o), 128'(0));
    cdb(1, 6'd9, 32'h99);
    step();
    idle();
    check_eq("ord.a_count", 128'(count_o), 128'(1));
    check_iss("ord.a", 32'hA0, 32'h99, 96'hAA);
    step();
    check_eq("ord.count0", 128'(count_o), 128'(0));

    // Enqueue snoop: operand captured from CDB in the enqueue cycle
    bus.iss_ready_i = 1'b0;
    set_slot(0, 32'h44, 1'b1, 6'd0, 32'h0, 1'b0, 6'd7, 96'h77);
    bus.enq_choose_i = 2'b01;
    bus.enq_valid_i  = 1'b1;
    cdb(1, 6'd7, 32'h55);
    step();
    idle();
    check_eq("snp.count", 128'(count_o), 128'(1));
    check_iss("snp.iss", 32'h44, 32'h55, 96'h77);
    bus.iss_ready_i = 1'b1;
    step();
    check_eq("snp.count0", 128'(count_o), 128'(0));

    // Full: reach DEPTH-1, issue under a blocked enqueue, then issue + 2-slot enqueue
    bus.iss_ready_i = 1'b0;
    for (int n = 0; n < 3; n++) begin
      set_slot(0, 32'h100 + 32'(2*n), 1'b1, 6'd0, 32'h1, 1'b1, 6'd0, 96'(n));
      set_slot(1, 32'h101 + 32'(2*n), 1'b1, 6'd0, 32'h1, 1'b1, 6'd0, 96'(n));
      bus.enq_choose_i = 2'b11;
      bus.enq_valid_i  = 1'b1;
      step();
    end
    set_slot(0, 32'h106, 1'b1, 6'd0, 32'h1, 1'b1, 6'd0, 96'h6);
    bus.enq_choose_i = 2'b01;
    step();
    idle();
    check_eq("full.count7", 128'(count_o), 128'(7));
    check_eq("full.enq_ready0", 128'(bus.enq_ready_o), 128'(0));
    check_eq("full.src0_e0", 128'(bus.iss_src0_o), 128'(32'h100));
    bus.iss_ready_i = 1'b1;
    set_slot(0, 32'h200, 1'b1, 6'd0, 32'h2, 1'b1, 6'd0, 96'h20);
    set_slot(1, 32'h201, 1'b1, 6'd0, 32'h2, 1'b1, 6'd0, 96'h21);
    bus.enq_choose_i = 2'b11;
    bus.enq_valid_i  = 1'b1;
    step();
    check_eq("full.count6", 128'(count_o), 128'(6));
    check_eq("full.enq_ready1", 128'(bus.enq_ready_o), 128'(1));
    check_eq("full.src0_e1", 128'(bus.iss_src0_o), 128'(32'h101));
    step();
    idle();
    check_eq("full.count7b", 128'(count_o), 128'(7));
    check_eq("full.enq_ready0b", 128'(bus.enq_ready_o), 128'(0));
    check_eq("full.src0_e2", 128'(bus.iss_src0_o), 128'(32'h102));

    // Flush priority
    step();
    step();
    check_eq("fl.count5", 128'(count_o), 128'(5));
    check_eq("fl.src0_e4", 128'(bus.iss_src0_o), 128'(32'h104));
    flush_i = 1'b1;
    set_slot(0, 32'h300, 1'b1, 6'd0, 32'h3, 1'b1, 6'd0, 96'h30);
    set_slot(1, 32'h301, 1'b1, 6'd0, 32'h3, 1'b1, 6'd0, 96'h31);
    bus.enq_choose_i = 2'b11;
    bus.enq_valid_i  = 1'b1;
    step();
    flush_i = 1'b0;
    bus.iss_ready_i = 1'b0;
    check_eq("fl.count0", 128'(count_o), 128'(0));
    check_eq("fl.iss_valid0", 128'(bus.iss_valid_o), 128'(0));
    check_eq("fl.enq_ready", 128'(bus.enq_ready_o), 128'(1));
    step();
    idle();
    check_eq("fl.count2", 128'(count_o), 128'(2));
    check_iss("fl.after", 32'h300, 32'h3, 96'h30);
    bus.iss_ready_i = 1'b1;
    step();
    step();
    check_eq("fl.drained", 128'(count_o), 128'(0));
    check_eq("fl.drained_valid", 128'(bus.iss_valid_o), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Out-of-order ALU issue queue, one instance per ALU lane, directly downstream of the dispatch stage.
- Accepts up to two dispatched instructions per cycle, each with two source operands and a per-operand ready flag.
- Operand readiness is tracked by snooping the two CDB write ports; operand data is captured when a tag matches.
- Each cycle the queue selects the oldest entry with both operands ready and issues it to the ALU over a valid/ready handshake.

Parameters:
- DEPTH, 8: number of queue entries (≥4).
- PREG_W, 6: physical register tag width.
- PAYLOAD_W, 96: opaque decode payload per instruction (op, grand_op, imm, pc, wreg_id, wreg, …), passed through unchanged.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush_i  in  1  pipeline flush; empties the queue.
- enq_valid_i  in  1  dispatch sender valid.
- enq_ready_o  out  1  dispatch receiver ready.
- enq_choose_i  in  2  per-slot select mask; bit k=1 means slot k targets this queue.
- enq_data_i  in  4x32  operand data, index 2k+s = slot k, source s.
- enq_preg_i  in  4xPREG_W  source tags, same indexing.
- enq_data_valid_i  in  4  operand already valid, same indexing.
- enq_payload_i  in  2xPAYLOAD_W  per-slot payload.
- cdb_w_reg_i  in  2  CDB port j writes a register.
- cdb_w_preg_i  in  2xPREG_W  CDB destination tags.
- cdb_w_data_i  in  2x32  CDB result data.
- iss_valid_o  out  1  issue valid.
- iss_ready_i  in  1  ALU accepts.
- iss_src0_o  out  32  operand 0 of the issued entry.
- iss_src1_o  out  32  operand 1 of the issued entry.
- iss_payload_o  out  PAYLOAD_W  payload of the issued entry.
- count_o  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- **Storage.** Collapsing queue: entry 0 is oldest, and valid entries occupy indices 0..count-1.
- **Reset/flush.** rst or flush_i at a clock edge sets count to 0 and clears all entry valid and ready bits. flush_i has priority over enqueue, wakeup and issue in the same cycle.
- **Reset output values.** iss_valid_o=0, count_o=0, enq_ready_o=1. iss_src0_o, iss_src1_o and iss_payload_o are 0 when iss_valid_o=0.
- **enq_ready_o.** Equals (DEPTH − count) ≥ 2, computed from registered count only. It does not depend on same-cycle issue, and it is independent of enq_valid_i.
- **Enqueue fire.** Fires when enq_valid_i & enq_ready_o & ~flush_i.
  - Selected slots are written at the tail in slot order; slot 0 is older than slot 1.
  - Mask 2'b10 writes slot 1 alone at the tail. Mask 2'b00 writes nothing.
- **Enqueue snoop.** For each enqueued operand with enq_data_valid_i=0: if any CDB port j has cdb_w_reg_i[j]=1 and a matching tag in the same cycle, the operand is stored valid with cdb_w_data_i[j]. If both ports match, the data is bitwise-ORed; producers guarantee this never happens.
- **Wakeup.** Each stored entry operand with valid=0 is compared against both CDB ports every cycle. On a match, data and valid=1 are written at the clock edge.
- **Selection.** Combinational over registered state. iss_valid_o=1 iff any entry has both operands valid; the lowest such index is presented.
  - An entry woken in cycle t is eligible at t+1 at the earliest. There is no same-cycle CDB bypass to issue.
- **Issue.** On iss_valid_o & iss_ready_i, the selected entry is removed and entries above it shift down one index.
  - iss_valid_o and the presented entry may change while not accepted, because an older entry can become ready. The consumer samples only on fire.
- **Simultaneous issue and enqueue.** Collapse happens first, then new entries are appended at index (count − issued), so final count = count − issued + enqueued.
- **Wakeup with shift.** Wakeup is applied to entry contents before shifting, so the update travels with the entry.
- **Full.** With count = DEPTH−1 or DEPTH, enq_ready_o=0 even if an issue fires in the same cycle.
- **Overflow.** Not possible by construction. An assertion checks count ≤ DEPTH.

Test Plan:
- **Reset values:** assert rst 2 cycles → iss_valid_o=0, count_o=0, enq_ready_o=1.
- **Immediate issue:** enqueue mask 2'b11, slot 0 all-ready (src 0x11/0x22), slot 1 with src1 waiting on preg 5 → next cycle iss 0x11/0x22 with slot 0 payload. Then CDB preg 5 data 0xABCD → slot 1 issues the following cycle with src1=0xABCD.
- **Oldest-ready ordering:** fill 3 entries A, B, C with A blocked on preg 9; B and C ready → B issues, then C. Wake preg 9 → A issues next, and count returns to 0.
- **Enqueue snoop:** enqueue an operand with data_valid=0 and preg 7 while the CDB broadcasts preg 7 data 0x55 → entry issues the next cycle with 0x55 and no further wakeup needed.
- **Full with issue:** reach count=DEPTH−1 (7) → enq_ready_o=0. Issue one entry → count 6, enq_ready_o=1 next cycle. Simultaneous issue and 2-slot enqueue at count 6 → count 7.
- **Flush priority:** count=5 with iss_ready_i=1 and enq fire in the same cycle as flush_i → next cycle count=0 and iss_valid_o=0. An enqueue in the following cycle works normally.
